// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: applies the FIPS-197 inverse S-box to a
// 128-bit state, LANES bytes per clock, with valid/ready on both sides.

module inv_sub_bytes_seq_sbox (
   input  logic [7:0] a,
   output logic [7:0] q
);
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign q = INV_SBOX[a];
endmodule

module inv_sub_bytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);
   localparam int unsigned N       = 16 / LANES;
   localparam int unsigned CW      = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CHUNK_W = 8 * LANES;
   localparam logic [CW-1:0] LAST  = CW'(N - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [127:0]         w;
   logic [127:0]         w_next;
   logic [CW-1:0]        cnt;
   logic [CHUNK_W-1:0]   chunk_in;
   logic [CHUNK_W-1:0]   chunk_out;

   // Select the chunk addressed by cnt; byte 0 sits at the MSB end.
   always_comb begin
      chunk_in = '0;
      for (int unsigned c = 0; c < N; c++) begin
         if (cnt == CW'(c)) chunk_in = w[127 - CHUNK_W*c -: CHUNK_W];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sub_bytes_seq_sbox u_sbox (
         .a (chunk_in [CHUNK_W-1-8*l -: 8]),
         .q (chunk_out[CHUNK_W-1-8*l -: 8])
      );
   end

   // Working value with the current chunk replaced, other bytes held.
   always_comb begin
      w_next = w;
      for (int unsigned c = 0; c < N; c++) begin
         if (cnt == CW'(c)) w_next[127 - CHUNK_W*c -: CHUNK_W] = chunk_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         w         <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  w        <= in_state;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               w <= w_next;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_state = w;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (LANES 1..16) on shared stimulus,
// checked every cycle against a transaction-level model built from GF(2^8) math.

module tb_inv_sub_bytes_seq;
   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_state;
   logic [4:0]   ir, ov, bz;
   logic [127:0] os [5];

   for (genvar g = 0; g < 5; g++) begin : g_dut
      inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .in_state  (in_state),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .out_state (os[g]),
         .busy      (bz[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit checking = 0;

   logic [7:0]   sbox_tab [256];
   logic [7:0]   inv_tab  [256];
   logic [127:0] cap      [5];
   int           xfers    [5];

   bit           m_busy [5];
   bit           m_zero [5];
   int           m_left [5];
   logic [127:0] m_res  [5];

   localparam logic [127:0] KV     = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] KV_OUT = 128'h000102030405060708090a0b0c0d0e0f;
   int lat_tab [5] = '{17, 9, 5, 3, 2};

   task automatic check(input string name, input int g, input logic [127:0] got, input logic [127:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s lanes=%0d got=%h want=%h", name, 1 << g, got, want);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Forward S-box from field inverse + affine map; inverse table by permutation inversion.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] xi;
         logic [7:0] b;
         xi = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
         end
         b = xi;
         sbox_tab[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) inv_tab[sbox_tab[x]] = 8'(x);
   endtask

   function automatic logic [127:0] inv_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tab[s[127 - 8*i -: 8]];
      return r;
   endfunction

   // Transaction model: accept when free, result valid N edges later, held until taken.
   always @(posedge clk) begin
      for (int g = 0; g < 5; g++) begin
         if (rst) begin
            m_busy[g] = 1'b0;
            m_left[g] = 0;
            m_zero[g] = 1'b1;
         end else if (!m_busy[g]) begin
            if (in_valid) begin
               m_busy[g] = 1'b1;
               m_left[g] = 16 >> g;
               m_res[g]  = inv_state(in_state);
               m_zero[g] = 1'b0;
            end
         end else if (m_left[g] > 0) begin
            m_left[g] = m_left[g] - 1;
         end else if (out_ready) begin
            m_busy[g] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      for (int g = 0; g < 5; g++) begin
         if (!rst && ov[g] && out_ready) begin
            cap[g]   <= os[g];
            xfers[g] <= xfers[g] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         for (int g = 0; g < 5; g++) begin
            bit exp_valid;
            exp_valid = m_busy[g] && (m_left[g] == 0);
            check("in_ready", g, 128'(ir[g]), 128'(!m_busy[g]));
            check("out_valid", g, 128'(ov[g]), 128'(exp_valid));
            check("busy", g, 128'(bz[g]), 128'(m_busy[g]));
            if (exp_valid) check("out_state", g, os[g], m_res[g]);
            else if (m_zero[g]) check("out_state_reset", g, os[g], 128'h0);
         end
      end
   end

   task automatic send(input logic [127:0] v);
      in_state = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ir != 5'h1f && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_timeout", 0, 128'(ir), 128'h1f);
   endtask

   task automatic check_all(input string name, input logic [127:0] want);
      for (int g = 0; g < 5; g++) check(name, g, cap[g], want);
   endtask

   initial begin
      int first [5];
      int matched [5];
      int xfer_snap [5];
      logic [7:0]   anc_in  [8] = '{8'h63, 8'h7c, 8'h00, 8'h01, 8'hff, 8'h16, 8'h52, 8'hed};
      logic [7:0]   anc_out [8] = '{8'h00, 8'h01, 8'h52, 8'h09, 8'h7d, 8'hff, 8'h48, 8'h53};
      logic [127:0] v;
      int n;

      build_tables();
      for (int g = 0; g < 5; g++) begin
         xfers[g] = 0;
         cap[g]   = '0;
      end
      for (int i = 0; i < 8; i++) check("model_anchor", 0, 128'(inv_tab[anc_in[i]]), 128'(anc_out[i]));

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_state = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checking = 1;
      for (int g = 0; g < 5; g++) begin
         check("reset_in_ready", g, 128'(ir[g]), 128'h1);
         check("reset_out_valid", g, 128'(ov[g]), 128'h0);
         check("reset_busy", g, 128'(bz[g]), 128'h0);
         check("reset_out_state", g, os[g], 128'h0);
      end

      // Known vector: latency per lane count and result.
      send(KV);
      for (int g = 0; g < 5; g++) first[g] = 0;
      for (int t = 1; t <= 20; t++) begin
         for (int g = 0; g < 5; g++) if (ov[g] && first[g] == 0) first[g] = t;
         @(negedge clk);
      end
      for (int g = 0; g < 5; g++) check("latency", g, 128'(first[g]), 128'(lat_tab[g]));
      check_all("known_vector", KV_OUT);

      send({16{8'h00}}); wait_idle(); check_all("uniform_00", {16{8'h52}});
      send({16{8'hff}}); wait_idle(); check_all("uniform_ff", {16{8'h7d}});
      send({16{8'h63}}); wait_idle(); check_all("uniform_63", {16{8'h00}});

      // Round trip over all 256 byte values.
      for (int g = 0; g < 5; g++) matched[g] = 0;
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = sbox_tab[16*b + i];
         send(v);
         wait_idle();
         for (int g = 0; g < 5; g++)
            for (int i = 0; i < 16; i++)
               if (cap[g][127 - 8*i -: 8] == 8'(16*b + i)) matched[g]++;
      end
      for (int g = 0; g < 5; g++) check("roundtrip_256", g, 128'(matched[g]), 128'd256);

      // Backpressure in DONE with in_valid toggling.
      out_ready = 1'b0;
      send(KV);
      n = 0;
      while (ov != 5'h1f && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid_timeout", 0, 128'(ov), 128'h1f);
      for (int i = 0; i < 6; i++) begin
         in_state = {16{8'h63}};
         in_valid = i[0];
         @(negedge clk);
         for (int g = 0; g < 5; g++) begin
            check("bp_stable", g, os[g], KV_OUT);
            check("bp_valid", g, 128'(ov[g]), 128'h1);
            check("bp_in_ready", g, 128'(ir[g]), 128'h0);
         end
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check_all("bp_transfer", KV_OUT);
      for (int g = 0; g < 5; g++) check("bp_no_bypass", g, 128'(ir[g]), 128'h1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int g = 0; g < 5; g++) check("bp_accept_next", g, 128'(ir[g]), 128'h0);
      wait_idle();
      check_all("bp_new_state", {16{8'h00}});

      // Reset two edges after acceptance.
      for (int g = 0; g < 5; g++) xfer_snap[g] = xfers[g];
      send(KV);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         check("rst_run_out_valid", g, 128'(ov[g]), 128'h0);
         check("rst_run_in_ready", g, 128'(ir[g]), 128'h1);
         check("rst_run_busy", g, 128'(bz[g]), 128'h0);
         check("rst_run_out_state", g, os[g], 128'h0);
      end
      repeat (20) @(negedge clk);
      for (int g = 0; g < 5; g++) check("rst_run_no_xfer", g, 128'(xfers[g]), 128'(xfer_snap[g]));
      send(KV);
      wait_idle();
      check_all("rst_run_fresh", KV_OUT);

      repeat (2) @(negedge clk);
      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential AES InvSubBytes engine. It applies the FIPS-197 inverse S-box to every byte of a 128-bit state, processing LANES bytes per clock. Handshakes are valid/ready on both input and output. It sits in the decryption datapath as the inverse of the forward byte substitution, between InvShiftRows and AddRoundKey.

## Interface
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16. Any other value is a configuration error.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state is presented.
- in_ready  out  1  block can accept a state. Equals 1 exactly when the FSM is in IDLE.
- in_state  in  128  ciphertext-side state. Byte i is in_state[127-8i -: 8], so byte 0 is the MSB byte.
- out_valid  out  1  out_state holds a complete result.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  128  inverse-substituted state, using the same byte ordering as in_state.
- busy  out  1  FSM is not in IDLE.

## Operation
- Inverse S-box: InvS(S(x)) = x for all 256 x, using the FIPS-197 table. Anchor values:
  - InvS(63)=00, InvS(7c)=01
  - InvS(00)=52, InvS(01)=09
  - InvS(ff)=7d, InvS(16)=ff
  - InvS(52)=48, InvS(ed)=53
- Datapath:
  - One 128-bit working register W, which drives out_state.
  - LANES combinational inverse S-box instances.
  - Chunk counter cnt, width log2(16/LANES) with a minimum of 1 bit.
  - N = 16/LANES.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, load W <= in_state, set cnt <= 0, go to RUN. Otherwise stay and hold W.
  - RUN: each cycle, bytes LANES*cnt through LANES*cnt+LANES-1 of W are replaced by InvS of themselves. All other bytes hold. Chunks are processed from byte 0 upward.
    - If cnt == N-1: go to DONE and clear cnt (wrap to 0).
    - Else cnt <= cnt+1.
    - in_valid is ignored.
  - DONE: out_valid=1 and W is frozen. If out_ready, go to IDLE. Otherwise stay.
- No input bypass: a new state is accepted only in IDLE, never in the same cycle as an output transfer.
- Outputs:
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
  - in_ready = (state==IDLE)
- All three are decoded from registered state with no combinational path from in_valid or out_ready.
- Reset, at any time including mid-RUN or in DONE:
  - state <= IDLE, W <= 0, cnt <= 0.
  - The partial result is discarded and no output transfer occurs.
- Reset values:
  - in_ready=1, out_valid=0, busy=0, out_state=128'h0.
- Simultaneous rst and in_valid: reset wins and the input is not accepted.

## Timing
- Input transfer happens at the edge where in_valid && in_ready. Call it edge k.
- RUN occupies cycles k+1 … k+N. out_valid is 1 from the cycle after edge k+N.
- Latency from acceptance edge to out_valid: N+1 edges.
  - LANES=4: 5 edges.
  - LANES=16: 2 edges.
  - LANES=1: 17 edges.
- Output transfer happens at an edge where out_valid && out_ready. in_ready rises in the following cycle.
- Minimum initiation interval: N+2 cycles.
- While out_valid=1 and out_ready=0, out_state must not change.
- In IDLE and RUN, out_state shows the working value and is not meaningful.

## Test plan
- Known vector, LANES=4: after reset, send in_state=637c777bf26b6fc53001672bfed7ab76 with out_ready=1. Required:
  - out_state=000102030405060708090a0b0c0d0e0f.
  - out_valid rises 5 edges after acceptance and stays high exactly 1 cycle.
  - in_ready returns 1 on the next cycle.
- Uniform states:
  - all-00 input gives all-52.
  - all-ff input gives all-7d.
  - all-63 input gives all-00.
- Exhaustive round trip: 16 blocks covering bytes 00…ff, each pre-mapped through the forward S-box. Every output byte must equal the original byte, and all 256 must match.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid with a new state. Required:
  - out_state is stable, out_valid=1, in_ready=0.
  - The new state is not accepted until after the output transfer plus 1 cycle.
- Reset mid-RUN: assert rst for 1 cycle two edges after acceptance. Required:
  - Next cycle: out_valid=0, in_ready=1, busy=0, out_state=0.
  - No out_valid pulse appears afterwards.
  - A fresh vector then completes correctly.
- Parameter sweep: rerun the known-vector scenario with LANES=1, 2, 8, 16. Latencies must be 17, 9, 3, 2 edges with identical out_state.
